// File: rtl/rr_mux_pkg.sv
// rtl/rr_mux_pkg.sv - shared types and round-robin search helper for rr_mux_arbiter
package rr_mux_pkg;

    typedef enum logic {ARB, LOCK} arb_state_t;

    localparam int MAX_IN = 16;

    // First requester after ptr, wrapping at n; returns ptr when nothing requests.
    function automatic logic [3:0] next_rr(input logic [MAX_IN-1:0] req,
                                           input logic [3:0] ptr,
                                           input int n);
        logic [3:0] idx;
        logic       found;
        next_rr = ptr;
        found   = 1'b0;
        for (int k = 1; k <= MAX_IN; k++) begin
            if (k <= n) begin
                idx = 4'((int'(ptr) + k) % n);
                if (!found && req[idx]) begin
                    next_rr = idx;
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin priority picker
module rr_pick
    import rr_mux_pkg::*;
#(
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              gnt_any
);

    assign gnt_idx = SEL_W'(next_rr(MAX_IN'(req), 4'(ptr), NUM_IN));
    assign gnt_any = |req;

endmodule

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin valid/ready arbiter with registered mux output and packet lock
module rr_mux_arbiter
    import rr_mux_pkg::*;
#(
    parameter  int NUM_IN   = 4,
    parameter  int DATA_W   = 8,
    parameter  int PKT_LOCK = 1,
    localparam int SEL_W    = $clog2(NUM_IN)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_IN-1:0]        in_valid,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [NUM_IN-1:0]        in_last,
    output logic [NUM_IN-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic [SEL_W-1:0]         out_sel,
    input  logic                     out_ready
);

    arb_state_t        state;
    logic [SEL_W-1:0]  ptr;
    logic [SEL_W-1:0]  lock_idx;
    logic [SEL_W-1:0]  rr_idx;
    logic [SEL_W-1:0]  gnt;
    logic              rr_any;
    logic              load;
    logic              xfer;
    logic [DATA_W-1:0] sel_data;
    logic              sel_last;

    rr_pick #(
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_pick (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt_idx (rr_idx),
        .gnt_any (rr_any)
    );

    assign load     = !out_valid || out_ready;
    assign gnt      = (state == LOCK) ? lock_idx : rr_idx;
    assign sel_data = in_data[int'(gnt)*DATA_W +: DATA_W];
    assign sel_last = in_last[gnt];
    assign xfer     = |(in_valid & in_ready);

    // While locked, ready stays on the locked channel even if it has stalled.
    always_comb begin
        in_ready = '0;
        if (!reset && load && (state == LOCK || rr_any)) begin
            in_ready[gnt] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_sel   <= '0;
            ptr       <= SEL_W'(NUM_IN - 1);
            lock_idx  <= '0;
            state     <= ARB;
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= sel_data;
                out_last  <= sel_last;
                out_sel   <= gnt;
                ptr       <= gnt;
                if (PKT_LOCK != 0) begin
                    if (state == ARB && !sel_last) begin
                        state    <= LOCK;
                        lock_idx <= gnt;
                    end else if (state == LOCK && sel_last) begin
                        state <= ARB;
                    end
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Sequential front end for the select-based mux blocks.
- Takes NUM_IN valid/ready request channels and arbitrates between them round-robin.
- Drives the select index and passes the selected word through a one-deep registered output stage.
- Optional packet lock holds the grant on one channel until that channel's in_last beat.

Parameters:
NUM_IN, 4, number of input channels (2..16)
DATA_W, 8, data width per channel
PKT_LOCK, 1, 1 = hold grant until in_last beat; 0 = re-arbitrate every beat
SEL_W, $clog2(NUM_IN), width of the select index (derived, not overridden)

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  NUM_IN  per-channel request/valid
in_data  input  NUM_IN*DATA_W  channel i data at [i*DATA_W +: DATA_W]
in_last  input  NUM_IN  per-channel last-beat-of-packet flag
in_ready  output  NUM_IN  per-channel accept; one-hot or zero
out_valid  output  1  output register holds a beat
out_data  output  DATA_W  registered selected data
out_last  output  1  registered in_last of the selected beat
out_sel  output  SEL_W  channel index the current output beat came from
out_ready  input  1  downstream accept

Behaviour:
- One clock, synchronous active-high reset; all state updates on the rising edge of clock.
- Reset values: out_valid=0, out_data=0, out_last=0, out_sel=0, rr pointer=NUM_IN-1 (channel 0 wins first), FSM=ARB.
- in_ready is combinational; it is 0 on every channel while reset=1.
- Load enable: load = !out_valid || out_ready (the output slot is free or being drained this cycle).
- Grant, ARB state:
  - gnt = the first i with in_valid[i]=1, searching cyclically from ptr+1, wrapping NUM_IN-1 -> 0.
  - in_ready[gnt] = load; all other in_ready bits are 0.
- Grant, LOCK state: gnt = locked channel. in_ready[lock] = load regardless of the other requests.
- Transfer on channel i: in_valid[i] && in_ready[i]. On that edge:
  - out_data <= channel i data, out_last <= in_last[i], out_sel <= i, out_valid <= 1.
  - ptr <= i.
- No transfer, but out_valid && out_ready: out_valid <= 0. out_data, out_last and out_sel hold their values.
- Latency: one cycle from input transfer to out_valid.
- Throughput: one beat per cycle while out_ready=1.
- FSM (used only when PKT_LOCK=1; with PKT_LOCK=0 the FSM stays in ARB):
  - ARB -> LOCK: on a transfer with in_last=0; lock <= granted index.
  - LOCK -> ARB: on a transfer from lock with in_last=1.
  - ARB -> ARB: on a transfer with in_last=1, i.e. single-beat packets.
  - Otherwise hold the current state.
- In LOCK, a stalled locked channel (in_valid=0) blocks all other channels. No timeout.
- Boundary conditions:
  - No requests: in_ready=0, ptr unchanged, out_valid drains on out_ready.
  - Single requester: granted every eligible cycle.
  - out_ready=0 with out_valid=1: output holds stable and all in_ready=0 (backpressure).
  - Simultaneous drain and load: back-to-back beats with no bubble.
  - Reset mid-packet: FSM returns to ARB, the output beat is discarded, ptr is reinitialised.
- Upstream assumptions: in_data and in_last are stable while in_valid=1 and not ready. Output obeys the same rule.

Decomposition:
- Package rr_mux_pkg:
  - typedef enum logic {ARB, LOCK} arb_state_t;
  - function next_rr(req, ptr) returning the cyclic-priority index.
- Sub-module rr_pick: purely combinational round-robin priority picker with ports req, ptr, gnt_idx, gnt_any.
- Top module holds the FSM, pointer, output register and in_ready generation.

Test Plan:
- Reset check: assert reset 3 cycles with all in_valid=1 -> out_valid=0, in_ready=0000 throughout. First post-reset grant is ch0, out_sel=0 one cycle later.
- Fairness, PKT_LOCK=0: in_valid=1111, in_last=1111, out_ready=1, data ch i=8'hA0+i -> out_data sequence A0,A1,A2,A3,A0..., one beat per cycle, no bubbles.
- Backpressure: out_ready=0 for 5 cycles after the first load -> out_data/out_sel stable, in_ready=0000. Release -> next channel granted in the same cycle.
- Packet lock: ch1 sends 3 beats (in_last on the 3rd) while ch2 requests continuously -> out_sel=1,1,1 then 2. With ch1 in_valid=0 mid-packet, ch2 is not granted.
- Wrap and sparse: only ch3 and ch0 request, ptr=3 -> order 0,3,0,3.
- Reset mid-packet: reset asserted after beat 2 of 4 -> state ARB, out_valid=0. Next grant is ch0 despite ch1 still requesting.
